// File: rtl/cell_plotter.sv
// rtl/cell_plotter.sv - rasterises one reversi board cell into single-pixel plot commands
// Grid lines, cursor ring, optional disc and green background, emitted in raster order.
module cell_plotter #(
    parameter int CELL_SIZE = 14,
    parameter int X_ORIGIN  = 24,
    parameter int Y_ORIGIN  = 4,
    parameter int INSET     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    output logic       ready,
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [1:0] piece,
    input  logic       highlight,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);

    localparam int CW = $clog2(CELL_SIZE);
    localparam logic [CW-1:0] LAST = CW'(CELL_SIZE - 1);
    localparam logic [CW-1:0] D_LO = CW'(INSET);
    localparam logic [CW-1:0] D_HI = CW'(CELL_SIZE - 1 - INSET);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] lx_q, lx_d, ly_q, ly_d;
    logic [2:0]    row_q, row_d, col_q, col_d;
    logic [1:0]    piece_q, piece_d;
    logic          hl_q, hl_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d, done_q, done_d, ready_q, ready_d;

    // The pixel being registered this edge: (0,0) of the incoming request while idle,
    // otherwise the raster successor of the pixel currently on the outputs.
    logic          idle, last_px, in_disc, ring;
    logic [CW-1:0] px_lx, px_ly;
    logic [2:0]    px_row, px_col;
    logic [1:0]    px_piece;
    logic          px_hl;
    logic [7:0]    pix_x;
    logic [6:0]    pix_y;
    logic [2:0]    pix_colour;

    assign idle     = (state_q == S_IDLE);
    assign last_px  = (lx_q == LAST) && (ly_q == LAST);
    assign px_lx    = idle ? '0 : ((lx_q == LAST) ? '0 : lx_q + ONE);
    assign px_ly    = idle ? '0 : ((lx_q == LAST) ? ly_q + ONE : ly_q);
    assign px_row   = idle ? row : row_q;
    assign px_col   = idle ? col : col_q;
    assign px_piece = idle ? piece : piece_q;
    assign px_hl    = idle ? highlight : hl_q;

    assign pix_x = 8'(X_ORIGIN) + 8'(px_col) * 8'(CELL_SIZE) + 8'(px_lx);
    assign pix_y = 7'(Y_ORIGIN) + 7'(px_row) * 7'(CELL_SIZE) + 7'(px_ly);

    assign ring    = (px_lx == ONE) || (px_ly == ONE) || (px_lx == LAST) || (px_ly == LAST);
    assign in_disc = (px_lx >= D_LO) && (px_lx <= D_HI) && (px_ly >= D_LO) && (px_ly <= D_HI)
                     && !(((px_lx == D_LO) || (px_lx == D_HI)) && ((px_ly == D_LO) || (px_ly == D_HI)));

    always_comb begin
        pix_colour = 3'b010;
        if (px_lx == '0 || px_ly == '0) begin
            pix_colour = 3'b000;
        end else if (px_hl && ring) begin
            pix_colour = 3'b100;
        end else if (in_disc && px_piece == 2'b01) begin
            pix_colour = 3'b000;
        end else if (in_disc && px_piece == 2'b10) begin
            pix_colour = 3'b111;
        end
    end

    always_comb begin
        state_d  = state_q;
        lx_d     = lx_q;
        ly_d     = ly_q;
        row_d    = row_q;
        col_d    = col_q;
        piece_d  = piece_q;
        hl_d     = hl_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (req) begin
                    state_d  = S_DRAW;
                    ready_d  = 1'b0;
                    row_d    = row;
                    col_d    = col;
                    piece_d  = piece;
                    hl_d     = highlight;
                    lx_d     = '0;
                    ly_d     = '0;
                    x_d      = pix_x;
                    y_d      = pix_y;
                    colour_d = pix_colour;
                    plot_d   = 1'b1;
                end
            end
            S_DRAW: begin
                if (last_px) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    lx_d     = px_lx;
                    ly_d     = px_ly;
                    x_d      = pix_x;
                    y_d      = pix_y;
                    colour_d = pix_colour;
                    plot_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lx_q     <= '0;
            ly_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            piece_q  <= '0;
            hl_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            row_q    <= row_d;
            col_q    <= col_d;
            piece_q  <= piece_d;
            hl_q     <= hl_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign done   = done_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_cell_plotter.sv
// tb/tb_cell_plotter.sv - randomized self-checking bench for cell_plotter
// Reference model computes each cell's pixel list and output timeline from the drawing rules.
module tb_cell_plotter;

    localparam int CS = 14;
    localparam int XO = 24;
    localparam int YO = 4;
    localparam int IN = 3;
    localparam int NPIX = CS * CS;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [2:0] row = '0;
    logic [2:0] col = '0;
    logic [1:0] piece = '0;
    logic       highlight = 1'b0;
    logic       ready, plot, done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    cell_plotter dut (
        .clock(clock), .reset(reset), .req(req), .ready(ready),
        .row(row), .col(col), .piece(piece), .highlight(highlight),
        .x(x), .y(y), .colour(colour), .plot(plot), .done(done)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_fail = 0;

    // Reference model state
    int       ex [NPIX];
    int       ey [NPIX];
    int       ec [NPIX];
    bit       busy = 0;
    int       age = 0;
    int       mx = 0, my = 0, mc = 0;
    int       acc_cnt = 0;
    int       cyc = 0;
    int       acc_cyc = 0;

    int       draw_plots = 0;
    int       done_cnt = 0;
    logic [2:0] scr [160][120];

    function automatic int ref_colour(int lx, int ly, int pc, bit hl);
        int lo = IN;
        int hi = CS - 1 - IN;
        if (lx == 0 || ly == 0) return 0;
        if (hl && (lx == 1 || ly == 1 || lx == CS - 1 || ly == CS - 1)) return 4;
        if ((pc == 1 || pc == 2) && lx >= lo && lx <= hi && ly >= lo && ly <= hi
            && !((lx == lo || lx == hi) && (ly == lo || ly == hi)))
            return (pc == 1) ? 0 : 7;
        return 2;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busy = 0; age = 0; mx = 0; my = 0; mc = 0;
        end else begin
            cyc++;
            if (busy) begin
                age++;
                if (age == NPIX + 2) busy = 0;
                else if (age <= NPIX) begin
                    mx = ex[age-1]; my = ey[age-1]; mc = ec[age-1];
                end
            end else if (req) begin
                for (int i = 0; i < NPIX; i++) begin
                    ex[i] = XO + int'(col) * CS + (i % CS);
                    ey[i] = YO + int'(row) * CS + (i / CS);
                    ec[i] = ref_colour(i % CS, i / CS, int'(piece), highlight);
                end
                busy = 1; age = 1;
                mx = ex[0]; my = ey[0]; mc = ec[0];
                acc_cnt++;
                acc_cyc = cyc;
            end
        end
    end

    always @(negedge clock) begin
        bit e_plot, e_done, e_ready;
        int e_x, e_y, e_c;
        if (reset) begin
            e_plot = 0; e_done = 0; e_ready = 1; e_x = 0; e_y = 0; e_c = 0;
        end else begin
            e_plot = busy && age <= NPIX;
            e_done = busy && age == NPIX + 1;
            e_ready = !busy;
            e_x = mx; e_y = my; e_c = mc;
        end
        n_vec++;
        if (plot !== e_plot || done !== e_done || ready !== e_ready ||
            x !== 8'(e_x) || y !== 7'(e_y) || colour !== 3'(e_c)) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t plot/done/ready/x/y/colour got %0d/%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d/%0d",
                     $time, plot, done, ready, x, y, colour, e_plot, e_done, e_ready, e_x, e_y, e_c);
        end
        if (plot === 1'b1) begin
            draw_plots++;
            if (x < 160 && y < 120) scr[x][y] = colour;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(string name, int act, int expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, act, expv);
        end
    endtask

    task automatic chk_pix(string name, int px, int py, int expv);
        chk(name, int'(scr[px][py]), expv);
    endtask

    task automatic draw(int r, int c, int p, int h, bit scramble);
        int n0 = acc_cnt;
        int t = 0;
        @(negedge clock);
        draw_plots = 0;
        row = 3'(r); col = 3'(c); piece = 2'(p); highlight = h[0]; req = 1'b1;
        while (acc_cnt == n0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (acc_cnt == n0) chk("accept_timeout", 0, 1);
        req = 1'b0;
        if (scramble) begin
            row = 3'($urandom); col = 3'($urandom); piece = 2'($urandom); highlight = 1'($urandom);
        end
    endtask

    task automatic wait_done(bit noisy);
        int t = 0;
        while (done !== 1'b1 && t < 400) begin
            if (noisy) begin
                req = 1'($urandom); row = 3'($urandom); col = 3'($urandom);
                piece = 2'($urandom); highlight = 1'($urandom);
            end
            @(negedge clock);
            t++;
        end
        req = 1'b0;
        if (done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) scr[i][j] = 3'd5;

        repeat (3) @(negedge clock);
        chk("reset_ready", int'(ready), 1);
        chk("reset_plot", int'(plot), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_xy", int'(x) + int'(y), 0);
        chk("reset_colour", int'(colour), 0);
        #2 reset = 1'b0;

        draw(0, 0, 0, 0, 1);
        wait_done(0);
        chk("r0c0_accept_to_done", cyc - acc_cyc, NPIX);
        chk("r0c0_ready_in_done", int'(ready), 0);
        chk("r0c0_plots", draw_plots, NPIX);
        @(negedge clock);
        chk("r0c0_ready_after", int'(ready), 1);
        chk_pix("r0c0_first", 24, 4, 0);
        chk_pix("r0c0_25_5", 25, 5, 2);
        chk_pix("r0c0_last", 37, 17, 2);

        draw(3, 4, 1, 0, 1);
        wait_done(0);
        chk_pix("r3c4_disc", 87, 53, 0);
        chk_pix("r3c4_corner", 83, 49, 2);
        chk_pix("r3c4_84_49", 84, 49, 0);
        chk_pix("r3c4_grid", 80, 47, 0);

        draw(7, 7, 2, 1, 1);
        wait_done(0);
        chk_pix("r7c7_ring", 123, 107, 4);
        chk_pix("r7c7_ring_last", 135, 115, 4);
        chk_pix("r7c7_white", 128, 108, 7);
        chk_pix("r7c7_grid", 122, 110, 0);

        draw(2, 2, 3, 0, 0);
        repeat (20) @(negedge clock);
        req = 1'b1; row = 3'd5;
        @(negedge clock);
        req = 1'b0;
        wait_done(0);
        chk_pix("piece11_centre", 59, 39, 2);
        chk_pix("ignored_req_cell", 59, 81, 5);
        chk("midreq_plots", draw_plots, NPIX);

        draw(1, 1, 1, 1, 0);
        begin
            int t = 0;
            while (draw_plots < 50 && t < 400) begin
                @(negedge clock);
                #1;
                t++;
            end
        end
        d0 = done_cnt;
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_plot", int'(plot), 0);
        chk("rst_mid_ready", int'(ready), 1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_mid_no_done", done_cnt, d0);
        chk("rst_mid_plots", draw_plots, 50);
        draw(1, 1, 1, 1, 1);
        wait_done(0);
        chk("after_rst_plots", draw_plots, NPIX);

        for (int k = 0; k < 15; k++) begin
            draw(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(3)),
                 int'($urandom_range(1)), 1);
            wait_done(1);
            chk("rand_plots", draw_plots, NPIX);
        end
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
